// File: rtl/move_arbiter_pkg.sv
// Shared types for the move arbiter: direction codes, issue-FSM states and requester IDs.
package move_arbiter_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_COOL  = 2'd2
  } state_e;

  localparam logic REQ_KB  = 1'b0;
  localparam logic REQ_BTN = 1'b1;

endpackage

// File: rtl/move_fifo.sv
// Move queue with two ordered write ports (port 0 lands before port 1) and one read port.
module move_fifo
  import move_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  dir_t                     wr0_data,
  input  logic                     wr1_en,
  input  dir_t                     wr1_data,
  input  logic                     rd_en,
  output dir_t                     rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dir_t            mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, wr1_addr;
  logic [CW-1:0]   count_q, count_d;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr1_addr = wptr_q + AW'(wr0_en);
    wptr_d   = wptr_q + AW'(wr0_en) + AW'(wr1_en);
    rptr_d   = rptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wptr_q]   <= wr0_data;
    if (wr1_en) mem_q[wr1_addr] <= wr1_data;
  end

  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;

endmodule

// File: rtl/move_arbiter.sv
// Merges keyboard and push-button move requests into a queue and issues them one at a
// time to the game logic, enforcing a cooldown after every accepted move.
module move_arbiter
  import move_arbiter_pkg::*;
#(
  parameter int COOLDOWN = 50000,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kb_valid,
  input  logic [1:0]             kb_dir,
  input  logic                   btn_valid,
  input  logic [1:0]             btn_dir,
  output logic                   mv_valid,
  output logic [1:0]             mv_dir,
  input  logic                   mv_ready,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   drop,
  output logic                   busy
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             drop_q, drop_d;

  logic             wr0_en, wr1_en, rd_en, both;
  dir_t             wr0_data, wr1_data, head, first_dir, second_dir;
  logic [CW-1:0]    occ, free_slots;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (wr1_data),
    .rd_en    (rd_en),
    .rd_data  (head),
    .count    (occ)
  );

  // Free space is judged on occupancy before this cycle's pop: no bypass.
  always_comb begin
    free_slots = CW'(DEPTH) - occ;
    both       = kb_valid & btn_valid;
    first_dir  = (prio_q == REQ_KB) ? kb_dir  : btn_dir;
    second_dir = (prio_q == REQ_KB) ? btn_dir : kb_dir;
    wr0_en     = 1'b0;
    wr1_en     = 1'b0;
    wr0_data   = kb_dir;
    wr1_data   = second_dir;
    drop_d     = 1'b0;
    prio_d     = both ? ~prio_q : prio_q;
    if (both) begin
      wr0_data = first_dir;
      if (free_slots >= CW'(2)) begin
        wr0_en = 1'b1;
        wr1_en = 1'b1;
      end else if (free_slots == CW'(1)) begin
        wr0_en = 1'b1;
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (kb_valid || btn_valid) begin
      wr0_data = kb_valid ? kb_dir : btn_dir;
      if (free_slots != '0) wr0_en = 1'b1;
      else                  drop_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE:  if (occ != '0) state_d = ST_OFFER;
      ST_OFFER: if (mv_ready) begin
        rd_en   = 1'b1;
        cnt_d   = CNT_W'(COOLDOWN);
        state_d = ST_COOL;
      end
      ST_COOL:  if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prio_q  <= REQ_KB;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      drop_q  <= drop_d;
    end
  end

  assign mv_valid = (state_q == ST_OFFER);
  assign mv_dir   = mv_valid ? head : DIR_UP;
  assign busy     = (state_q == ST_COOL);
  assign drop     = drop_q;
  assign q_count  = occ;

endmodule
